// File: rtl/m_ifetch.sv
// m_ifetch: instruction-fetch stage. Owns the PC, drives a synchronous
// instruction memory with 1-cycle read latency, and hands {pc, ir} pairs to
// decode through a 2-entry FIFO with a valid/ready handshake. A redirect
// flushes everything fetched but not yet consumed and restarts at the target.
module m_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'h0000_0004
) (
    input  logic        w_clk,
    input  logic        w_rst,
    output logic        w_imem_en,
    output logic [31:0] w_imem_addr,
    input  logic [31:0] w_imem_data,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc,
    output logic        w_out_valid,
    input  logic        w_out_ready,
    output logic [31:0] w_out_pc,
    output logic [31:0] w_out_ir
);

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflightPc_q, inflightPc_d;
    logic        kill_q, kill_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [31:0] fifoPc_q [2];
    logic [31:0] fifoIr_q [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;

    // Handshake, credit check and fetch request; reset forces the request low
    always_comb begin
        w_out_valid = !w_rst && (count_q != 2'd0) && !w_redirect;
        pop         = w_out_valid && w_out_ready;
        occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue       = !w_rst && !w_redirect && (occupancy < 3'd2);
        push        = inflight_q && !kill_q && !w_redirect;
        w_imem_en   = issue;
        w_imem_addr = pc_q;
        w_out_pc    = 32'h0;
        w_out_ir    = 32'h0;
        if (count_q != 2'd0) begin
            w_out_pc = fifoPc_q[head_q];
            w_out_ir = fifoIr_q[head_q];
        end
    end

    // Next-state for PC, in-flight tracking and FIFO bookkeeping
    always_comb begin
        pc_d         = pc_q;
        inflight_d   = issue;
        inflightPc_d = inflightPc_q;
        kill_d       = kill_q;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};
        head_d       = head_q ^ pop;
        tail_d       = tail_q ^ push;
        if (issue) begin
            pc_d         = pc_q + PC_INC;
            inflightPc_d = pc_q;
        end
        if (inflight_q) begin
            kill_d = 1'b0;
        end
        if (w_redirect) begin
            pc_d    = {w_redirect_pc[31:2], 2'b00};
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
            // Only a request still outstanding past the redirect needs killing;
            // with 1-cycle latency and no issue during redirect this stays clear.
            kill_d  = issue;
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            pc_q         <= RESET_PC;
            inflight_q   <= 1'b0;
            inflightPc_q <= 32'h0;
            kill_q       <= 1'b0;
            count_q      <= 2'd0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
        end else begin
            assert (!(push && (count_q == 2'd2)));
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            kill_q       <= kill_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
        end
    end

    // FIFO storage; contents only matter where count says an entry is live
    always_ff @(posedge w_clk) begin
        if (push) begin
            fifoPc_q[tail_q] <= inflightPc_q;
            fifoIr_q[tail_q] <= w_imem_data;
        end
    end

endmodule

// File: tb/tb_m_ifetch.sv
// tb_m_ifetch: directed test of m_ifetch with a behavioural 1-cycle imem that
// returns 32'h1000_0000 | addr. A second instance starts near the top of the
// address space to exercise PC wrap-around.
module tb_m_ifetch;

    logic        w_clk = 1'b0;
    logic        w_rst;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_out_ready;

    logic        imemEn, outValid;
    logic [31:0] imemAddr, imemData, outPc, outIr;

    logic        wrapImemEn, wrapOutValid;
    logic [31:0] wrapImemAddr, wrapImemData, wrapOutPc, wrapOutIr;

    int compared   = 0;
    int mismatched = 0;

    // Free-running clock, period 10
    always #5 w_clk = ~w_clk;

    m_ifetch dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .w_imem_en    (imemEn),
        .w_imem_addr  (imemAddr),
        .w_imem_data  (imemData),
        .w_redirect   (w_redirect),
        .w_redirect_pc(w_redirect_pc),
        .w_out_valid  (outValid),
        .w_out_ready  (w_out_ready),
        .w_out_pc     (outPc),
        .w_out_ir     (outIr)
    );

    m_ifetch #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .w_imem_en    (wrapImemEn),
        .w_imem_addr  (wrapImemAddr),
        .w_imem_data  (wrapImemData),
        .w_redirect   (1'b0),
        .w_redirect_pc(32'h0),
        .w_out_valid  (wrapOutValid),
        .w_out_ready  (1'b1),
        .w_out_pc     (wrapOutPc),
        .w_out_ir     (wrapOutIr)
    );

    // Synchronous instruction memories with 1-cycle read latency
    always @(posedge w_clk) begin
        if (imemEn) imemData <= 32'h1000_0000 | imemAddr;
        if (wrapImemEn) wrapImemData <= 32'h1000_0000 | wrapImemAddr;
    end

    // Guard against the run never finishing
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic expectHead(input string tag, input logic v, input logic [31:0] pc);
        checkOutput({tag, ".valid"}, {31'h0, outValid}, {31'h0, v});
        if (v) begin
            checkOutput({tag, ".pc"}, outPc, pc);
            checkOutput({tag, ".ir"}, outIr, 32'h1000_0000 | pc);
        end
    endtask

    task automatic expectFetch(input string tag, input logic en, input logic [31:0] addr);
        checkOutput({tag, ".en"}, {31'h0, imemEn}, {31'h0, en});
        if (en) checkOutput({tag, ".addr"}, imemAddr, addr);
    endtask

    task automatic expectWrap(input string tag, input logic [31:0] pc);
        checkOutput({tag, ".valid"}, {31'h0, wrapOutValid}, 32'h1);
        checkOutput({tag, ".pc"}, wrapOutPc, pc);
        checkOutput({tag, ".ir"}, wrapOutIr, 32'h1000_0000 | pc);
    endtask

    // Advance one cycle, drive inputs just after the edge, sample at negedge
    task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] target);
        @(posedge w_clk);
        #1;
        w_out_ready   = ready;
        w_redirect    = redir;
        w_redirect_pc = target;
        @(negedge w_clk);
    endtask

    initial begin
        w_rst         = 1'b1;
        w_out_ready   = 1'b1;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        @(posedge w_clk);
        @(posedge w_clk);
        @(negedge w_clk);
        checkOutput("rst.valid", {31'h0, outValid}, 32'h0);
        checkOutput("rst.en", {31'h0, imemEn}, 32'h0);
        checkOutput("rst.pc", outPc, 32'h0);
        checkOutput("rst.ir", outIr, 32'h0);
        checkOutput("rst.addr", imemAddr, 32'h0);
        checkOutput("rst.wrapAddr", wrapImemAddr, 32'hFFFF_FFF8);

        // Startup and steady state
        @(posedge w_clk);
        #1 w_rst = 1'b0;
        @(negedge w_clk);
        expectHead("c0", 1'b0, 32'h0);
        expectFetch("c0", 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("c1", 1'b0, 32'h0);
        expectFetch("c1", 1'b1, 32'h4);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("c2", 1'b1, 32'h0);
        expectWrap("wrap0", 32'hFFFF_FFF8);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("c3", 1'b1, 32'h4);
        expectWrap("wrap1", 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("c4", 1'b1, 32'h8);
        expectWrap("wrap2", 32'h0000_0000);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("c5", 1'b1, 32'hC);
        expectWrap("wrap3", 32'h0000_0004);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("c6", 1'b1, 32'h10);

        // Backpressure for five cycles: head holds, fetch stalls
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            expectHead($sformatf("stall%0d", i), 1'b1, 32'h14);
            expectFetch($sformatf("stall%0d", i), 1'b0, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("rel0", 1'b1, 32'h14);
        expectFetch("rel0", 1'b1, 32'h1C);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("rel1", 1'b1, 32'h18);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("rel2", 1'b1, 32'h1C);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("rel3", 1'b1, 32'h20);

        // Redirect with one buffered entry and a response arriving
        applyStimulus(1'b0, 1'b1, 32'h0000_0203);
        expectHead("redir", 1'b0, 32'h0);
        expectFetch("redir", 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("redir1", 1'b0, 32'h0);
        expectFetch("redir1", 1'b1, 32'h200);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("redir2", 1'b0, 32'h0);
        expectFetch("redir2", 1'b1, 32'h204);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("redir3", 1'b1, 32'h200);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("redir4", 1'b1, 32'h204);

        // Back-to-back redirects: the second target wins
        applyStimulus(1'b1, 1'b1, 32'h40);
        expectHead("b2bA", 1'b0, 32'h0);
        expectFetch("b2bA", 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h80);
        expectHead("b2bB", 1'b0, 32'h0);
        expectFetch("b2bB", 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("b2b1", 1'b0, 32'h0);
        expectFetch("b2b1", 1'b1, 32'h80);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectFetch("b2b2", 1'b1, 32'h84);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("b2b3", 1'b1, 32'h80);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("b2b4", 1'b1, 32'h84);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("b2b5", 1'b1, 32'h88);

        // Asynchronous reset between edges while output is valid
        @(posedge w_clk);
        #2;
        expectHead("preRst", 1'b1, 32'h8C);
        #2 w_rst = 1'b1;
        #1;
        checkOutput("midRst.valid", {31'h0, outValid}, 32'h0);
        checkOutput("midRst.en", {31'h0, imemEn}, 32'h0);
        checkOutput("midRst.pc", outPc, 32'h0);
        checkOutput("midRst.ir", outIr, 32'h0);
        checkOutput("midRst.addr", imemAddr, 32'h0);
        @(posedge w_clk);
        @(posedge w_clk);
        #1 w_rst = 1'b0;
        @(negedge w_clk);
        expectHead("re0", 1'b0, 32'h0);
        expectFetch("re0", 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("re1", 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("re2", 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        expectHead("re3", 1'b1, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
